// File: rtl/rg_gpio_bank_if.sv
// Register bus between the CPU IO-space decoder and the GPIO bank.
// The decoder drives the master side; rdata is combinational from addr.
interface rg_gpio_bank_if #(
  parameter int P_AW    = 4,
  parameter int P_WIDTH = 8
);
  logic [P_AW-1:0]    addr;
  logic [P_WIDTH-1:0] wdata;
  logic               wbe;
  logic [P_WIDTH-1:0] rdata;

  modport master (output addr, output wdata, output wbe, input rdata);
  modport slave  (input addr, input wdata, input wbe, output rdata);
endinterface

// File: rtl/rg_gpio_bank.sv
// GPIO register bank: per-port DDR/PORT/PIN/PCMSK, pad synchronizer,
// pin-change detection with arm suppression and per-port interrupt requests.
module rg_gpio_bank #(
  parameter int                           P_PORTS       = 3,
  parameter int                           P_WIDTH       = 8,
  parameter logic [P_PORTS*P_WIDTH-1:0]   P_IMPL_MASK   = '1,
  parameter int                           P_SYNC_STAGES = 2,
  parameter int                           P_AW          = $clog2(4*P_PORTS+2)
) (
  input  logic                       clk,
  input  logic                       nrst,
  rg_gpio_bank_if.slave              bus,
  input  logic [P_PORTS*P_WIDTH-1:0] pin_i,
  output logic [P_PORTS*P_WIDTH-1:0] port_o,
  output logic [P_PORTS*P_WIDTH-1:0] ddr_o,
  output logic [P_PORTS-1:0]         pcint_o
);

  localparam int N       = P_PORTS * P_WIDTH;
  localparam int ARM_MAX = P_SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);
  localparam logic [P_AW-1:0] ADDR_PCIFR = P_AW'(4*P_PORTS);
  localparam logic [P_AW-1:0] ADDR_PCICR = P_AW'(4*P_PORTS + 1);

  typedef enum logic [1:0] {
    REG_PIN   = 2'd0,
    REG_DDR   = 2'd1,
    REG_PORT  = 2'd2,
    REG_PCMSK = 2'd3
  } reg_e;

  logic [P_SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]       pin_s, prev_q, chg;
  logic [N-1:0]       ddr_q, port_q, pcmsk_q;
  logic [N-1:0]       ddr_d, port_d, pcmsk_d;
  logic [P_PORTS-1:0] pcifr_q, pcicr_q, pcifr_d, pcicr_d;
  logic [P_PORTS-1:0] port_chg, w1c;
  logic [P_WIDTH-1:0] wmask;
  logic [ARM_W-1:0]   arm_q;
  logic               armed;

  assign pin_s = sync_q[P_SYNC_STAGES-1];
  assign armed = (arm_q == ARM_W'(ARM_MAX));
  assign chg   = (pin_s ^ prev_q) & pcmsk_q & P_IMPL_MASK;

  always_comb begin
    port_chg = '0;
    for (int p = 0; p < P_PORTS; p++)
      port_chg[p] = armed & (|chg[p*P_WIDTH +: P_WIDTH]);
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ddr_d   = ddr_q;
    port_d  = port_q;
    pcmsk_d = pcmsk_q;
    pcicr_d = pcicr_q;
    w1c     = '0;
    wmask   = '0;
    if (bus.wbe) begin
      for (int p = 0; p < P_PORTS; p++) begin
        if (bus.addr[P_AW-1:2] == (P_AW-2)'(p)) begin
          wmask = bus.wdata & P_IMPL_MASK[p*P_WIDTH +: P_WIDTH];
          case (reg_e'(bus.addr[1:0]))
            REG_PIN:   port_d[p*P_WIDTH +: P_WIDTH]  = port_q[p*P_WIDTH +: P_WIDTH] ^ wmask;
            REG_DDR:   ddr_d[p*P_WIDTH +: P_WIDTH]   = wmask;
            REG_PORT:  port_d[p*P_WIDTH +: P_WIDTH]  = wmask;
            REG_PCMSK: pcmsk_d[p*P_WIDTH +: P_WIDTH] = wmask;
          endcase
        end
      end
      if (bus.addr == ADDR_PCIFR) w1c     = bus.wdata[P_PORTS-1:0];
      if (bus.addr == ADDR_PCICR) pcicr_d = bus.wdata[P_PORTS-1:0];
    end
    // A hardware set in the same cycle as a write-1-to-clear wins.
    pcifr_d = (pcifr_q & ~w1c) | port_chg;
  end

  always_comb begin
    bus.rdata = '0;
    for (int p = 0; p < P_PORTS; p++) begin
      if (bus.addr[P_AW-1:2] == (P_AW-2)'(p)) begin
        case (reg_e'(bus.addr[1:0]))
          REG_PIN:   bus.rdata = pin_s[p*P_WIDTH +: P_WIDTH] & P_IMPL_MASK[p*P_WIDTH +: P_WIDTH];
          REG_DDR:   bus.rdata = ddr_q[p*P_WIDTH +: P_WIDTH];
          REG_PORT:  bus.rdata = port_q[p*P_WIDTH +: P_WIDTH];
          REG_PCMSK: bus.rdata = pcmsk_q[p*P_WIDTH +: P_WIDTH];
        endcase
      end
    end
    if (bus.addr == ADDR_PCIFR) bus.rdata = P_WIDTH'(pcifr_q);
    if (bus.addr == ADDR_PCICR) bus.rdata = P_WIDTH'(pcicr_q);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values (e.g. detection sees the old PCMSK).
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q  <= '0;
      prev_q  <= '0;
      ddr_q   <= '0;
      port_q  <= '0;
      pcmsk_q <= '0;
      pcifr_q <= '0;
      pcicr_q <= '0;
      arm_q   <= '0;
    end else begin
      if (P_SYNC_STAGES > 1) sync_q <= {sync_q[P_SYNC_STAGES-2:0], pin_i};
      else                   sync_q <= pin_i;
      prev_q  <= pin_s;
      ddr_q   <= ddr_d;
      port_q  <= port_d;
      pcmsk_q <= pcmsk_d;
      pcifr_q <= pcifr_d;
      pcicr_q <= pcicr_d;
      // Detection stays off until the synchronizer and prev sample hold real pad data.
      if (!armed) arm_q <= arm_q + ARM_W'(1);
    end
  end

  assign port_o  = port_q;
  assign ddr_o   = ddr_q;
  assign pcint_o = pcifr_q & pcicr_q;

endmodule

// File: tb/tb_rg_gpio_bank.sv
// Self-checking bench for rg_gpio_bank: directed scenarios with literal
// expectations plus randomized traffic against a behavioural register model.
module tb_rg_gpio_bank;

  localparam int P  = 3;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int N  = P * W;
  localparam int AW = $clog2(4*P+2);
  localparam logic [N-1:0] IMPL = 24'hFF_3F_FF;

  logic         clk   = 1'b0;
  logic         nrst  = 1'b1;
  logic [N-1:0] pin_i = '1;
  logic [N-1:0] port_o, ddr_o;
  logic [P-1:0] pcint_o;

  int n_checks = 0;
  int n_pass   = 0;

  rg_gpio_bank_if #(.P_AW(AW), .P_WIDTH(W)) bus ();

  rg_gpio_bank #(
    .P_PORTS(P), .P_WIDTH(W), .P_IMPL_MASK(IMPL), .P_SYNC_STAGES(S)
  ) dut (
    .clk(clk), .nrst(nrst), .bus(bus),
    .pin_i(pin_i), .port_o(port_o), .ddr_o(ddr_o), .pcint_o(pcint_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_ddr  [P];
  logic [W-1:0] m_port [P];
  logic [W-1:0] m_msk  [P];
  logic [P-1:0] m_flag, m_en;
  logic [N-1:0] hist [S+1];   // hist[i] = pad value sampled i edges ago
  int           edges;

  function automatic logic [W-1:0] impl(input int p);
    return IMPL[p*W +: W];
  endfunction

  function automatic int a_int();
    return int'(bus.addr);
  endfunction

  function automatic logic [P-1:0] pin_changes();
    logic [P-1:0] r = '0;
    if (edges >= S + 1)
      for (int p = 0; p < P; p++)
        r[p] = |((hist[S-1][p*W +: W] ^ hist[S][p*W +: W]) & m_msk[p] & impl(p));
    return r;
  endfunction

  function automatic logic [P-1:0] w1c_bits();
    return (bus.wbe && a_int() == 4*P) ? bus.wdata[P-1:0] : '0;
  endfunction

  function automatic logic [W-1:0] exp_rd();
    int a = a_int();
    if (a < 4*P) begin
      case (a % 4)
        0:       return hist[S-1][(a/4)*W +: W] & impl(a/4);
        1:       return m_ddr[a/4];
        2:       return m_port[a/4];
        default: return m_msk[a/4];
      endcase
    end
    if (a == 4*P)     return W'(m_flag);
    if (a == 4*P + 1) return W'(m_en);
    return '0;
  endfunction

  function automatic logic [N-1:0] exp_vec(input bit want_ddr);
    logic [N-1:0] r = '0;
    for (int p = 0; p < P; p++) r[p*W +: W] = want_ddr ? m_ddr[p] : m_port[p];
    return r;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int p = 0; p < P; p++) begin
        m_ddr[p]  <= '0;
        m_port[p] <= '0;
        m_msk[p]  <= '0;
      end
      for (int i = 0; i <= S; i++) hist[i] <= '0;
      m_flag <= '0;
      m_en   <= '0;
      edges  <= 0;
    end else begin
      hist[0] <= pin_i;
      for (int i = 1; i <= S; i++) hist[i] <= hist[i-1];
      if (edges < S + 1) edges <= edges + 1;
      m_flag <= (m_flag & ~w1c_bits()) | pin_changes();
      if (bus.wbe && a_int() < 4*P) begin
        case (a_int() % 4)
          0:       m_port[a_int()/4] <= m_port[a_int()/4] ^ (bus.wdata & impl(a_int()/4));
          1:       m_ddr[a_int()/4]  <= bus.wdata & impl(a_int()/4);
          2:       m_port[a_int()/4] <= bus.wdata & impl(a_int()/4);
          default: m_msk[a_int()/4]  <= bus.wdata & impl(a_int()/4);
        endcase
      end
      if (bus.wbe && a_int() == 4*P + 1) m_en <= bus.wdata[P-1:0];
    end
  end

  always @(negedge clk) begin
    if (nrst) begin
      check("model_rdata", 32'(bus.rdata), 32'(exp_rd()));
      check("model_port_o", 32'(port_o), 32'(exp_vec(1'b0)));
      check("model_ddr_o", 32'(ddr_o), 32'(exp_vec(1'b1)));
      check("model_pcint_o", 32'(pcint_o), 32'(m_flag & m_en));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    bus.addr  = AW'(a);
    bus.wdata = d;
    bus.wbe   = 1'b1;
    cyc();
    bus.wbe   = 1'b0;
  endtask

  task automatic rd_chk(input string name, input int a, input logic [W-1:0] exp);
    bus.addr = AW'(a);
    bus.wbe  = 1'b0;
    @(negedge clk);
    check(name, 32'(bus.rdata), 32'(exp));
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.addr  = '0;
    bus.wdata = '0;
    bus.wbe   = 1'b0;
    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: release with pads high; PCMSK0 enabled on the first edge, arm suppression keeps PCIFR clear
    nrst      = 1'b1;
    bus.addr  = AW'(3);
    bus.wdata = 8'hFF;
    bus.wbe   = 1'b1;
    cyc();
    bus.wbe   = 1'b0;
    bus.addr  = AW'(0);
    @(negedge clk);
    check("pin_after_1clk", 32'(bus.rdata), 32'h00);
    cyc();
    @(negedge clk);
    check("pin_after_2clk", 32'(bus.rdata), 32'hFF);
    repeat (4) cyc();
    rd_chk("arm_no_flag", 4*P, 8'h00);

    // 2: PIN-write toggle
    wr(1, 8'h5A);
    wr(2, 8'h0F);
    wr(0, 8'hF0);
    rd_chk("toggle_f0", 2, 8'hFF);
    wr(0, 8'h81);
    rd_chk("toggle_81", 2, 8'h7E);
    rd_chk("ddr_unaffected", 1, 8'h5A);
    check("port_o_toggle", 32'(port_o[7:0]), 32'h7E);

    // 3: masked change latency and unmasked toggle
    wr(3, 8'h04);
    wr(4*P + 1, 8'h01);
    pin_i[2] = 1'b0;
    repeat (5) cyc();
    wr(4*P, 8'h07);
    rd_chk("flags_cleared", 4*P, 8'h00);
    pin_i[2] = 1'b1;
    cyc();
    @(negedge clk);
    check("pcint_lat1", 32'(pcint_o[0]), 32'd0);
    cyc();
    @(negedge clk);
    check("pcint_lat2", 32'(pcint_o[0]), 32'd0);
    cyc();
    @(negedge clk);
    check("pcint_lat3", 32'(pcint_o[0]), 32'd1);
    cyc();
    rd_chk("pcifr_set", 4*P, 8'h01);
    wr(4*P, 8'h01);
    pin_i[3] = ~pin_i[3];
    repeat (5) cyc();
    rd_chk("unmasked_no_flag", 4*P, 8'h00);

    // 4: set and W1C on the same edge, set wins
    pin_i[2] = 1'b0;
    cyc();
    cyc();
    bus.addr  = AW'(4*P);
    bus.wdata = 8'h01;
    bus.wbe   = 1'b1;
    cyc();
    bus.wbe   = 1'b0;
    rd_chk("set_beats_w1c", 4*P, 8'h01);
    wr(4*P, 8'h01);
    rd_chk("w1c_alone", 4*P, 8'h00);
    check("pcint_after_w1c", 32'(pcint_o[0]), 32'd0);

    // 5: partially implemented port 1 and unmapped address
    wr(5, 8'hFF);
    wr(6, 8'hFF);
    rd_chk("ddr1_impl", 5, 8'h3F);
    rd_chk("port1_impl", 6, 8'h3F);
    check("ddr_o_unimpl", 32'(ddr_o[15:14]), 32'd0);
    check("port_o_unimpl", 32'(port_o[15:14]), 32'd0);
    wr(4*P + 2, 8'hFF);
    rd_chk("unmapped_read", 4*P + 2, 8'h00);

    // 6: asynchronous reset mid-operation
    wr(2, 8'hAA);
    wr(3, 8'hFF);
    wr(7, 8'hFF);
    wr(11, 8'hFF);
    wr(4*P + 1, 8'h07);
    pin_i = pin_i ^ 24'h01_01_01;
    repeat (4) cyc();
    rd_chk("pcifr_all", 4*P, 8'h07);
    check("pcint_all", 32'(pcint_o), 32'h7);
    #2 nrst = 1'b0;
    #1;
    check("rst_port_o", 32'(port_o), 32'h0);
    check("rst_ddr_o", 32'(ddr_o), 32'h0);
    check("rst_pcint_o", 32'(pcint_o), 32'h0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    cyc();
    rd_chk("rst_port0", 2, 8'h00);
    rd_chk("rst_ddr0", 1, 8'h00);
    rd_chk("rst_pcifr", 4*P, 8'h00);
    rd_chk("rst_pcicr", 4*P + 1, 8'h00);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      bus.addr  = AW'($urandom_range(0, 2**AW - 1));
      bus.wdata = W'($urandom);
      bus.wbe   = ($urandom_range(0, 2) == 0);
      pin_i     = pin_i ^ N'($urandom & $urandom & $urandom);
      cyc();
    end
    bus.wbe = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
